// File: rtl/sr_latch_driver.sv
// sr_latch_driver: sequences S/R/En for an external gated SR latch.
// Each set or reset command runs SETUP -> PULSE -> HOLD -> GUARD.
// S/R settle one cycle before En rises and stay put one cycle after it falls.
// Every output is registered. The register inputs are computed from the
// next state, so the outputs line up with the state they describe.
module sr_latch_driver #(
  parameter int unsigned PULSE_CYC = 2,
  parameter int unsigned GUARD_CYC = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  input  logic [1:0] cmd_op,
  output logic       cmd_ready,
  input  logic       err_clr,
  output logic       S,
  output logic       R,
  output logic       En,
  output logic       busy,
  output logic       done,
  output logic       q_exp,
  output logic       q_valid,
  output logic       err
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_PULSE,
    ST_HOLD,
    ST_GUARD
  } state_t;

  localparam logic [1:0] OP_NOP   = 2'b00;
  localparam logic [1:0] OP_SET   = 2'b01;
  localparam logic [1:0] OP_RESET = 2'b10;
  localparam logic [1:0] OP_ILL   = 2'b11;

  // The down-counter is loaded with N-1, so the state lasts exactly N cycles.
  localparam logic [7:0] PULSE_LOAD = 8'(PULSE_CYC - 1);
  localparam logic [7:0] GUARD_LOAD = 8'(GUARD_CYC - 1);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       op_set_q, op_set_d;   // 1 = set command in flight, 0 = reset
  logic       s_q, s_d;
  logic       r_q, r_d;
  logic       en_q, en_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       q_exp_q, q_exp_d;
  logic       q_valid_q, q_valid_d;
  logic       err_q, err_d;
  logic       accept;
  logic       drive_sr;

  assign cmd_ready = (state_q == ST_IDLE);
  assign accept    = cmd_valid && (state_q == ST_IDLE);

  // Next-state logic, counter control and next values for the registered outputs.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_set_d  = op_set_q;
    q_exp_d   = q_exp_q;
    q_valid_d = q_valid_q;
    done_d    = 1'b0;
    // A clear applies first, so an illegal op accepted on the same edge still sets err.
    err_d     = err_q & ~err_clr;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          case (cmd_op)
            OP_SET: begin
              op_set_d = 1'b1;
              state_d  = ST_SETUP;
            end
            OP_RESET: begin
              op_set_d = 1'b0;
              state_d  = ST_SETUP;
            end
            OP_NOP: begin
              done_d = 1'b1;
            end
            OP_ILL: begin
              err_d = 1'b1;
            end
            default: begin
              state_d = ST_IDLE;
            end
          endcase
        end
      end
      ST_SETUP: begin
        state_d = ST_PULSE;
        cnt_d   = PULSE_LOAD;
      end
      ST_PULSE: begin
        if (cnt_q == 8'd0) begin
          state_d   = ST_HOLD;
          q_exp_d   = op_set_q;
          q_valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      ST_HOLD: begin
        state_d = ST_GUARD;
        cnt_d   = GUARD_LOAD;
      end
      ST_GUARD: begin
        if (cnt_q == 8'd0) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 8'd0;
      end
    endcase

    // S/R are driven from SETUP through HOLD. En is high only in PULSE,
    // so S/R only ever change while En is low.
    drive_sr = (state_d == ST_SETUP) || (state_d == ST_PULSE) || (state_d == ST_HOLD);
    s_d      = drive_sr & op_set_d;
    r_d      = drive_sr & ~op_set_d;
    en_d     = (state_d == ST_PULSE);
    busy_d   = (state_d != ST_IDLE);
  end

  // State, counter and output registers. Reset is immediate so the latch is released at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 8'd0;
      op_set_q  <= 1'b0;
      s_q       <= 1'b0;
      r_q       <= 1'b0;
      en_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      q_exp_q   <= 1'b0;
      q_valid_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_set_q  <= op_set_d;
      s_q       <= s_d;
      r_q       <= r_d;
      en_q      <= en_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      q_exp_q   <= q_exp_d;
      q_valid_q <= q_valid_d;
      err_q     <= err_d;
    end
  end

  assign S       = s_q;
  assign R       = r_q;
  assign En      = en_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign q_exp   = q_exp_q;
  assign q_valid = q_valid_q;
  assign err     = err_q;

endmodule

// File: tb/tb_sr_latch_driver.sv
// Bench for sr_latch_driver. It uses a directed vector table, hand-written
// corner sequences and a random run. A timeline model checks every cycle.
module tb_sr_latch_driver;

  localparam int unsigned PULSE_CYC = 2;
  localparam int unsigned GUARD_CYC = 1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic [1:0] cmd_op;
  logic       cmd_ready;
  logic       err_clr;
  logic       S, R, En, busy, done, q_exp, q_valid, err;

  int checks   = 0;
  int failures = 0;

  sr_latch_driver #(.PULSE_CYC(PULSE_CYC), .GUARD_CYC(GUARD_CYC)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_op(cmd_op),
    .cmd_ready(cmd_ready), .err_clr(err_clr), .S(S), .R(R), .En(En),
    .busy(busy), .done(done), .q_exp(q_exp), .q_valid(q_valid), .err(err)
  );

  always #5 clk = ~clk;

  // Packed view: {S,R,En,busy,done,q_exp,q_valid,err,cmd_ready}
  function automatic logic [8:0] outs();
    return {S, R, En, busy, done, q_exp, q_valid, err, cmd_ready};
  endfunction

  // ---------------- reference model: queue of planned output cycles ----------------
  typedef struct packed {
    bit s; bit r; bit en; bit busy; bit done; bit upd; bit qv;
  } cyc_t;

  cyc_t cyc_idle = '0;
  cyc_t cur;
  cyc_t plan[$];
  bit   m_q, m_qv, m_err;

  function automatic logic [8:0] model_outs();
    return {cur.s, cur.r, cur.en, cur.busy, cur.done, m_q, m_qv, m_err, ~cur.busy};
  endfunction

  task automatic model_reset();
    cur = '0;
    plan.delete();
    m_q = 0; m_qv = 0; m_err = 0;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        model_reset();
      end else begin
        bit acc;
        bit is_set;
        cyc_t c;
        acc = cmd_valid && !cur.busy;
        if (acc && (cmd_op == 2'b01 || cmd_op == 2'b10)) begin
          is_set = (cmd_op == 2'b01);
          c = '0; c.busy = 1; c.s = is_set; c.r = !is_set;
          plan.push_back(c);                          // setup
          c.en = 1;
          for (int k = 0; k < int'(PULSE_CYC); k++) plan.push_back(c);
          c.en = 0; c.upd = 1; c.qv = is_set;
          plan.push_back(c);                          // hold
          c = '0; c.busy = 1;
          for (int k = 0; k < int'(GUARD_CYC); k++) plan.push_back(c);
          c = '0; c.done = 1;
          plan.push_back(c);                          // done cycle
        end
        cur = (plan.size() != 0) ? plan.pop_front() : cyc_idle;
        if (acc && cmd_op == 2'b00) cur.done = 1;
        if (cur.upd) begin
          m_q = cur.qv;
          m_qv = 1;
        end
        if (err_clr) m_err = 0;
        if (acc && cmd_op == 2'b11) m_err = 1;
      end
    end
  end

  // ---------------- per-cycle checker and latch-safety invariants ----------------
  logic ps, pr, pe;
  initial begin
    ps = 0; pr = 0; pe = 0;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1) begin
        checks++;
        if (outs() !== model_outs()) begin
          failures++;
          $display("FAIL model t=%0t got=%b exp=%b (S,R,En,busy,done,q,qv,err,rdy)",
                   $time, outs(), model_outs());
        end
        checks++;
        if (S && R) begin
          failures++;
          $display("FAIL s_and_r t=%0t got S=%b R=%b exp not both 1", $time, S, R);
        end
        checks++;
        if ((En || pe) && (S !== ps || R !== pr)) begin
          failures++;
          $display("FAIL sr_stable t=%0t got S/R=%b%b prev=%b%b En=%b prevEn=%b exp unchanged",
                   $time, S, R, ps, pr, En, pe);
        end
      end
      ps = S; pr = R; pe = En;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_bits(input string name, input logic [8:0] got, input logic [8:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%b exp=%b", name, got, exp);
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit         vld;
    logic [1:0] op;
    bit         clr;
    logic [8:0] exp;   // {S,R,En,busy,done,q,qv,err,rdy} after the edge
  } vec_t;

  vec_t tab[19];

  initial begin
    int en_cnt, rise_cnt, guard;
    bit pb;

    tab[0]  = '{1, 2'b01, 0, 9'b100100000};
    tab[1]  = '{0, 2'b00, 0, 9'b101100000};
    tab[2]  = '{0, 2'b00, 0, 9'b101100000};
    tab[3]  = '{0, 2'b00, 0, 9'b100101100};
    tab[4]  = '{0, 2'b00, 0, 9'b000101100};
    tab[5]  = '{0, 2'b00, 0, 9'b000011101};
    tab[6]  = '{1, 2'b10, 0, 9'b010101100};
    tab[7]  = '{0, 2'b00, 0, 9'b011101100};
    tab[8]  = '{0, 2'b00, 0, 9'b011101100};
    tab[9]  = '{0, 2'b00, 0, 9'b010100100};
    tab[10] = '{0, 2'b00, 0, 9'b000100100};
    tab[11] = '{0, 2'b00, 0, 9'b000010101};
    tab[12] = '{1, 2'b11, 0, 9'b000000111};
    tab[13] = '{0, 2'b00, 0, 9'b000000111};
    tab[14] = '{0, 2'b00, 1, 9'b000000101};
    tab[15] = '{1, 2'b11, 1, 9'b000000111};
    tab[16] = '{0, 2'b00, 1, 9'b000000101};
    tab[17] = '{1, 2'b00, 0, 9'b000010101};
    tab[18] = '{0, 2'b00, 0, 9'b000000101};

    rst_n = 1'b0; cmd_valid = 0; cmd_op = 2'b00; err_clr = 0;
    #12;
    expect_bits("reset_state", outs(), 9'b000000001);
    @(posedge clk); #3 rst_n = 1'b1;
    tick();

    for (int i = 0; i < 19; i++) begin
      cmd_valid = tab[i].vld; cmd_op = tab[i].op; err_clr = tab[i].clr;
      tick();
      expect_bits($sformatf("vec%0d", i), outs(), tab[i].exp);
      $display("vec %0d vld=%0d op=%b clr=%0d out=%b", i, tab[i].vld, tab[i].op, tab[i].clr, outs());
    end
    cmd_valid = 0; err_clr = 0;
    tick();

    // cmd_valid held through a set: only one more acceptance, taken in the done cycle
    cmd_valid = 1; cmd_op = 2'b01;
    en_cnt = 0; rise_cnt = 0; pb = busy;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (En) en_cnt++;
      if (busy && !pb) rise_cnt++;
      pb = busy;
    end
    cmd_valid = 0;
    expect_bits("held_en_cycles", 9'(en_cnt), 9'(2 * PULSE_CYC));
    expect_bits("held_accepts", 9'(rise_cnt), 9'd2);
    $display("held valid: en_cycles=%0d accepts=%0d", en_cnt, rise_cnt);
    repeat (10) tick();

    // reset during PULSE: everything drops immediately
    cmd_valid = 1; cmd_op = 2'b01;
    tick(); cmd_valid = 0;
    tick();
    expect_bits("mid_in_pulse", {8'd0, En}, 9'd1);
    #2 rst_n = 1'b0;
    #1 expect_bits("mid_reset_now", {En, busy, q_valid, S, R, done, err, q_exp, cmd_ready}, 9'b000000001);
    $display("mid-op reset applied out=%b", outs());
    @(posedge clk); #3 rst_n = 1'b1;
    tick();
    cmd_valid = 1; cmd_op = 2'b01;
    tick(); cmd_valid = 0;
    guard = 0;
    while (!done && guard < 20) begin tick(); guard++; end
    expect_bits("after_reset_set", {6'd0, done, q_exp, q_valid}, 9'b000000111);
    $display("post-reset set done after %0d cycles q_exp=%b", guard, q_exp);

    // random run with occasional asynchronous resets
    for (int k = 0; k < 3000; k++) begin
      cmd_valid = 1'($urandom_range(0, 1));
      cmd_op    = 2'($urandom_range(0, 3));
      err_clr   = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 199) == 0) begin
        #2 rst_n = 1'b0;
        #1 expect_bits("rand_reset", {En, busy, q_valid, S, R, 4'd0}, 9'd0);
        #2 rst_n = 1'b1;
      end
      tick();
    end
    cmd_valid = 0; err_clr = 0;
    repeat (5) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sr_latch_driver.md
SR_LATCH_DRIVER -- requirements
Module: sr_latch_driver

Interface
REQ-001 SHALL have parameter PULSE_CYC, default 2, the enable-high width in clock cycles; legal range 1..255.
REQ-002 SHALL have parameter GUARD_CYC, default 1, the idle cycles with S=R=En=0 after each command; legal range 1..255.
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all state is updated on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit, the reset: asynchronous and active-low.
REQ-005 SHALL have port cmd_valid, input, 1 bit, meaning a command is offered.
REQ-006 SHALL have port cmd_op, input, 2 bits: 00 nop, 01 set, 10 reset, 11 illegal.
REQ-007 SHALL have port cmd_ready, output, 1 bit, meaning the block can accept a command.
REQ-008 SHALL have port err_clr, input, 1 bit, which clears the sticky error.
REQ-009 SHALL have ports S, R and En, outputs, 1 bit each, which drive the gated SR latch.
REQ-010 SHALL have port busy, output, 1 bit, meaning a command is in progress.
REQ-011 SHALL have port done, output, 1 bit, a single-cycle completion pulse.
REQ-012 SHALL have port q_exp, output, 1 bit, the expected latch Q.
REQ-013 SHALL have port q_valid, output, 1 bit, meaning q_exp is meaningful.
REQ-014 SHALL have port err, output, 1 bit, the sticky illegal-command flag.

Function
REQ-015 SHALL drive every output from a register (no combinational input-to-output path), except cmd_ready, which SHALL equal (state==IDLE).
REQ-016 SHALL accept a command on the rising edge where cmd_valid && cmd_ready; cmd_valid while busy SHALL be ignored and the requester holds it.
REQ-017 SHALL use the states IDLE, SETUP, PULSE, HOLD and GUARD.
REQ-018 SHALL move IDLE->SETUP on acceptance of op 01 or 10.
REQ-019 SHALL, in SETUP (1 cycle), drive S/R to the op (set: S=1 R=0; reset: S=0 R=1) with En=0.
REQ-020 SHALL, in PULSE (PULSE_CYC cycles), keep S/R unchanged with En=1.
REQ-021 SHALL, in HOLD (1 cycle), keep S/R unchanged with En=0.
REQ-022 SHALL, in GUARD (GUARD_CYC cycles), drive S=R=En=0, then move to IDLE.
REQ-023 SHALL track cycles in PULSE and GUARD with one down-counter of 8 bits, loaded with N-1 on entry; the state exits when the counter reaches 0.
REQ-024 SHALL never drive S=1 and R=1 at the same time.
REQ-025 SHALL change S/R only while En=0, so S/R are stable one cycle before, during and one cycle after every En-high window.
REQ-026 SHALL make busy = 1 in every state other than IDLE.
REQ-027 SHALL pulse done for exactly one cycle, in the first IDLE cycle after GUARD.
REQ-028 SHALL, on leaving PULSE, set q_exp to 1 for set and 0 for reset, and set q_valid to 1.
REQ-029 SHALL, on acceptance of op 00 (nop), stay in IDLE, drive no S/R/En activity, and pulse done on the next cycle; q_exp is unchanged.
REQ-030 SHALL, on acceptance of op 11, stay in IDLE, set err, not pulse done, and leave S/R/En and q_exp unchanged.
REQ-031 SHALL clear err one cycle after err_clr=1; if err_clr and an illegal op are accepted in the same cycle, err SHALL end at 1 (set wins).
REQ-032 SHALL allow back-to-back commands: a command offered during the done cycle is accepted on that cycle's edge, since cmd_ready=1.

Reset
REQ-033 SHALL, while rst_n=0, force immediately (asynchronously): state IDLE, counter 0, S=R=En=0, busy=0, done=0, q_exp=0, q_valid=0, err=0.
REQ-034 SHALL, on reset mid-command, abort the command with no further En pulse; after release it starts in IDLE with cmd_ready=1.

Verification (defaults PULSE_CYC=2, GUARD_CYC=1; edge 0 = acceptance edge)
REQ-035 Set: op=01 accepted at edge 0 -> cycle 1 S=1 R=0 En=0; cycles 2-3 En=1; cycle 4 En=0 S=1, q_exp=1, q_valid=1; cycle 5 S=R=En=0; cycle 6 done=1, busy=0.
REQ-036 Reset after set: op=10 accepted in the done cycle -> the same timing with R=1, and q_exp=0 from the HOLD cycle.
REQ-037 Illegal and clear: op=11 accepted -> err=1, no done, S=R=En=0 throughout; then err_clr=1 -> err=0 next cycle; op=11 with err_clr=1 in the same cycle -> err=1.
REQ-038 Busy and nop: cmd_valid held during a set -> no second acceptance until IDLE; op=00 -> done=1 one cycle later with no En pulse.
REQ-039 Reset mid-operation: rst_n=0 during PULSE -> En=0, q_valid=0 and busy=0 immediately; after release, op=01 completes normally.
REQ-040 The bench SHALL check on every cycle that !(S&&R), and that S/R never change while En=1 or in the cycle En rises.
